// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: RV32I register-file widths and the writeback entry type shared by the arbiter and its buffer.
// Revision 1.0
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`default_nettype none

package rf_wb_arbiter_pkg;

  localparam int NUM_REGS = 1 << `RF_ADDR_WIDTH;

  typedef struct packed {
    logic [`RF_ADDR_WIDTH-1:0] rd;
    logic [`WORD_WIDTH-1:0]    data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// wb_fifo: power-of-two FIFO of pending load writebacks; pointers carry one extra wrap bit.
// Revision 1.0
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`default_nettype none

module wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  wb_entry_t wdata_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;
  wb_entry_t   mem_q [DEPTH];

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges ALU and buffered load results onto one register-file write port with anti-starvation.
// Revision 1.0. Optional pending-write scoreboard enabled by defining RF_WB_SCOREBOARD_EN.
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`default_nettype none

module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alu_valid,
  input  logic [`RF_ADDR_WIDTH-1:0] alu_rd,
  input  logic [`WORD_WIDTH-1:0]    alu_data,
  output logic                      alu_stall,
  input  logic                      mem_valid,
  input  logic [`RF_ADDR_WIDTH-1:0] mem_rd,
  input  logic [`WORD_WIDTH-1:0]    mem_data,
  output logic                      mem_ready,
  input  logic                      iss_valid,
  input  logic [`RF_ADDR_WIDTH-1:0] iss_rd,
  input  logic [`RF_ADDR_WIDTH-1:0] chk_rs1,
  input  logic [`RF_ADDR_WIDTH-1:0] chk_rs2,
  output logic                      busy_rs1,
  output logic                      busy_rs2,
  output logic                      rf_we,
  output logic [`RF_ADDR_WIDTH-1:0] rf_waddr,
  output logic [`WORD_WIDTH-1:0]    rf_wdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t                 mem_entry, fifo_head;
  logic                      fifo_full, fifo_empty;
  logic                      force_fifo, grant_alu, grant_fifo;
  logic [CW-1:0]             starve_q, starve_d;
  logic                      rf_we_q, rf_we_d;
  logic [`RF_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [`WORD_WIDTH-1:0]    rf_wdata_q, rf_wdata_d;

  assign mem_entry = '{rd: mem_rd, data: mem_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wb_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (mem_valid),
    .wdata_i (mem_entry),
    .pop_i   (grant_fifo),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign mem_ready = !fifo_full;

  // Count reaching the limit means the head was refused that many cycles in a row.
  always_comb begin
    force_fifo = (starve_q == CW'(STARVE_LIMIT)) && !fifo_empty;
    grant_alu  = alu_valid && !force_fifo;
    grant_fifo = !grant_alu && !fifo_empty;
    alu_stall  = alu_valid && force_fifo;
    starve_d   = (fifo_empty || grant_fifo) ? '0 : starve_q + CW'(1);
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_alu) begin
      rf_we_d    = (alu_rd != '0);
      rf_waddr_d = alu_rd;
      rf_wdata_d = alu_data;
    end else if (grant_fifo) begin
      rf_we_d    = (fifo_head.rd != '0);
      rf_waddr_d = fifo_head.rd;
      rf_wdata_d = fifo_head.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef RF_WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] sb_q, sb_d;

  // Set is applied after clear so a same-cycle reissue keeps the register busy.
  always_comb begin
    sb_d = sb_q;
    if (grant_fifo) sb_d[fifo_head.rd] = 1'b0;
    if (iss_valid && (iss_rd != '0)) sb_d[iss_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end

  assign busy_rs1 = sb_q[chk_rs1];
  assign busy_rs2 = sb_q[chk_rs2];
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{iss_valid, iss_rd, chk_rs1, chk_rs2};
  assign busy_rs1 = 1'b0;
  assign busy_rs2 = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed self-checking bench for rf_wb_arbiter (FIFO_DEPTH=2, STARVE_LIMIT=4).
// Revision 1.0
`default_nettype none

module tb_rf_wb_arbiter;

  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid, mem_valid, iss_valid;
  logic [4:0]  alu_rd, mem_rd, iss_rd, chk_rs1, chk_rs2;
  logic [31:0] alu_data, mem_data;
  logic        alu_stall, mem_ready, busy_rs1, busy_rs2, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic acc;
  int pushed, seen;
  bit full_seen;
  logic [4:0]  prd  [3] = '{5'd10, 5'd11, 5'd12};
  logic [31:0] pdat [3] = '{32'hA0, 32'hB1, 32'hC2};

  rf_wb_arbiter #(
    .FIFO_DEPTH   (FIFO_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_stall (alu_stall),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .busy_rs1  (busy_rs1),
    .busy_rs2  (busy_rs2),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    iss_valid = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
    #3;
    check("rst_we", rf_we, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_mem_ready", mem_ready, 1);
    check("rst_stall", alu_stall, 0);
    check("rst_busy", busy_rs1, 0);
    step(); step();
    rst_n = 1;

    // ALU-only write
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    step();
    check("alu_we", rf_we, 1);
    check("alu_waddr", rf_waddr, 5);
    check("alu_wdata", rf_wdata, 32'hDEADBEEF);
    alu_valid = 0;
    step();
    check("idle_we", rf_we, 0);
    check("idle_wdata_hold", rf_wdata, 32'hDEADBEEF);

    // Contention: ALU continuous, one load waiting
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    mem_valid = 1; mem_rd = 7; mem_data = 32'h11;
    check("cont_mem_ready", mem_ready, 1);
    step();
    mem_valid = 0;
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      check("cont_no_stall", alu_stall, 0);
      check("cont_alu_waddr", rf_waddr, 3);
      step();
    end
    check("cont_forced_stall", alu_stall, 1);
    step();
    check("cont_mem_we", rf_we, 1);
    check("cont_mem_waddr", rf_waddr, 7);
    check("cont_mem_wdata", rf_wdata, 32'h11);
    check("cont_stall_clear", alu_stall, 0);
    step();
    check("cont_alu_resume", rf_waddr, 3);

    // Full FIFO with ALU busy: three loads must all land, in order
    pushed = 0; seen = 0; full_seen = 0;
    for (int cyc = 0; cyc < 80 && seen < 3; cyc++) begin
      if (pushed < 3) begin
        mem_valid = 1; mem_rd = prd[pushed]; mem_data = pdat[pushed];
      end else begin
        mem_valid = 0;
      end
      if (pushed == 2 && !full_seen) begin
        check("full_mem_ready", mem_ready, 0);
        full_seen = 1;
      end
      acc = mem_valid && mem_ready;
      step();
      if (acc) pushed++;
      if (rf_we && rf_waddr != 5'd3) begin
        check("full_order_rd", rf_waddr, prd[seen]);
        check("full_order_data", rf_wdata, pdat[seen]);
        seen++;
      end
    end
    check("full_all_written", seen, 3);
    mem_valid = 0; alu_valid = 0;
    step(); step();

    // Load to x0: consumed without a write
    mem_valid = 1; mem_rd = 0; mem_data = 32'h55;
    step();
    mem_valid = 0;
    step();
    check("rd0_we", rf_we, 0);
    check("rd0_mem_ready", mem_ready, 1);
    mem_valid = 1; mem_rd = 14; mem_data = 32'h77;
    step();
    mem_valid = 0;
    step();
    check("rd0_next_we", rf_we, 1);
    check("rd0_next_waddr", rf_waddr, 14);
    check("rd0_next_wdata", rf_wdata, 32'h77);

`ifdef RF_WB_SCOREBOARD_EN
    iss_valid = 1; iss_rd = 9; chk_rs1 = 9; chk_rs2 = 0;
    step();
    iss_valid = 0;
    check("sb_busy_set", busy_rs1, 1);
    check("sb_other_clear", busy_rs2, 0);
    iss_valid = 1; iss_rd = 0;
    step();
    iss_valid = 0;
    check("sb_x0_never", busy_rs2, 0);
    mem_valid = 1; mem_rd = 9; mem_data = 32'h99;
    step();
    mem_valid = 0;
    iss_valid = 1; iss_rd = 9;
    check("sb_busy_at_grant", busy_rs1, 1);
    step();
    iss_valid = 0;
    check("sb_reissue_busy", busy_rs1, 1);
    check("sb_reissue_waddr", rf_waddr, 9);
    mem_valid = 1; mem_rd = 9; mem_data = 32'h9A;
    step();
    mem_valid = 0;
    check("sb_busy_grant2", busy_rs1, 1);
    step();
    check("sb_busy_cleared", busy_rs1, 0);
`else
    iss_valid = 1; iss_rd = 9; chk_rs1 = 9; chk_rs2 = 9;
    step();
    iss_valid = 0;
    check("nosb_busy1", busy_rs1, 0);
    check("nosb_busy2", busy_rs2, 0);
`endif

    // Reset mid-run with two buffered loads
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    chk_rs1 = 9;
    iss_valid = 1; iss_rd = 9;
    mem_valid = 1; mem_rd = 20; mem_data = 32'h20;
    step();
    iss_valid = 0;
    mem_rd = 21; mem_data = 32'h21;
    step();
    mem_valid = 0;
    check("mr_full_before", mem_ready, 0);
    #2;
    rst_n = 0;
    #1;
    check("mr_we", rf_we, 0);
    check("mr_mem_ready", mem_ready, 1);
    check("mr_busy", busy_rs1, 0);
    check("mr_stall", alu_stall, 0);
    alu_valid = 0;
    step(); step();
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("mr_no_stale_we", rf_we, 0);
    end
    check("mr_ready_after", mem_ready, 1);
    check("mr_busy_after", busy_rs1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameters, one per line:
  FIFO_DEPTH, 2, entries in the memory-writeback buffer (power of two, >=2)
  STARVE_LIMIT, 4, consecutive denied cycles before the memory channel forces a grant
REQ-002 SHALL have ports, one per line:
  clk  in  1  single clock; all state on rising edge
  rst_n  in  1  reset, asynchronous, active-low
  alu_valid  in  1  single-cycle result present
  alu_rd  in  `RF_ADDR_WIDTH  ALU destination register
  alu_data  in  `WORD_WIDTH  ALU result
  alu_stall  out  1  ALU result not taken; upstream holds alu_* stable
  mem_valid  in  1  long-latency (load) result present
  mem_rd  in  `RF_ADDR_WIDTH  load destination
  mem_data  in  `WORD_WIDTH  load data
  mem_ready  out  1  buffer can accept; transfer on mem_valid && mem_ready
  iss_valid  in  1  long-latency instruction issued
  iss_rd  in  `RF_ADDR_WIDTH  its destination
  chk_rs1, chk_rs2  in  `RF_ADDR_WIDTH  decode source registers
  busy_rs1, busy_rs2  out  1  source has a pending long-latency write
  rf_we  out  1  register-file write enable
  rf_waddr  out  `RF_ADDR_WIDTH  register-file write address
  rf_wdata  out  `WORD_WIDTH  register-file write data

Function
REQ-003 SHALL buffer memory results in a FIFO_DEPTH-entry FIFO; mem_ready = !full (combinational from state only).
REQ-004 SHALL drive rf_we/rf_waddr/rf_wdata from registers: a granted result appears exactly 1 cycle after grant.
REQ-005 SHALL grant ALU whenever alu_valid and no forced grant is pending; otherwise grant FIFO head if non-empty.
REQ-006 SHALL count consecutive cycles with FIFO non-empty and FIFO denied; at count == STARVE_LIMIT the next cycle SHALL grant FIFO head, assert alu_stall if alu_valid, and clear the count.
REQ-007 SHALL clear the starvation count on any FIFO grant or when FIFO is empty.
REQ-008 SHALL treat rd == 0 as consumed but produce rf_we = 0 for that cycle.
REQ-009 SHALL deassert rf_we in any cycle following no grant; rf_waddr/rf_wdata then hold their last value.
REQ-010 SHALL support push and pop in the same cycle when full (pop frees the slot only next cycle; mem_ready stays 0 that cycle).
REQ-011 SHALL keep a 32-bit pending scoreboard: iss_valid sets bit iss_rd; FIFO-head grant clears bit of its rd.
REQ-012 SHALL give set priority over clear when both target the same register in one cycle.
REQ-013 SHALL drive busy_rsN = scoreboard[chk_rsN] combinationally; x0 SHALL never read busy; iss_rd == 0 SHALL not set.
REQ-014 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH with an extra bit to separate full from empty.

Reset
REQ-015 SHALL on rst_n low immediately clear FIFO pointers, starvation count, scoreboard, rf_we, rf_waddr, rf_wdata, alu_stall.
REQ-016 SHALL discard all buffered memory results on reset mid-operation; after release mem_ready = 1, busy = 0.

Configuration
REQ-017 SHALL compile the scoreboard only when RF_WB_SCOREBOARD_EN is defined; without it busy_rs1/busy_rs2 tie to 0, iss_* are ignored, no scoreboard storage exists.

Structure
REQ-018 SHALL take `RF_ADDR_WIDTH/`WORD_WIDTH from the common RV32I definitions; a shared package SHALL hold the wb_entry_t typedef (rd, data).
REQ-019 SHALL implement the buffer as sub-module wb_fifo (parameterised depth, wb_entry_t payload).

Verification
REQ-020 ALU only: alu_valid, rd=5, data=0xDEADBEEF -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-021 Contention: ALU and mem (rd=7, 0x11) both valid, ALU continuous -> mem written after exactly STARVE_LIMIT denied cycles, alu_stall=1 that grant cycle.
REQ-022 Full: 3 mem pushes with ALU busy, FIFO_DEPTH=2 -> mem_ready=0 after 2nd, 3rd held, no data lost or reordered.
REQ-023 rd=0: mem result rd=0 -> entry popped, rf_we stays 0.
REQ-024 Scoreboard: iss rd=9, check rs1=9 -> busy_rs1=1 until cycle after mem rd=9 grant; same-cycle reissue of 9 keeps busy=1.
REQ-025 Reset mid-run: FIFO holding 2 entries, rst_n pulse -> rf_we=0, mem_ready=1, busy=0, no stale writes after release.
